// File: rtl/denoise_top_hls_deadlock_pkg.sv
// Shared definitions for the dataflow deadlock report unit: FSM encoding,
// index-width helper and the hop-counter width.
package denoise_top_hls_deadlock_pkg;

  // Report-unit controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ORIGIN = 3'd1,
    TRACE  = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Width of the hop counter and of the reported hop count
  localparam int HOPS_W = 16;

  // Index width for n processes, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/denoise_top_hls_deadlock_prio_enc.sv
// Lowest-set-index priority encoder: picks which reporting process becomes
// the origin of a deadlock trace when several report at once.
module denoise_top_hls_deadlock_prio_enc
  import denoise_top_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM = 4,
  localparam int IDX_W = idx_w(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] req,
  output logic [IDX_W-1:0]    idx,
  output logic                valid
);

  // Scan from the top down so the lowest set bit is the last (winning) write
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/denoise_top_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process among the detect units,
// injects a one-cycle origin token, traces which processes re-report until
// the token returns (or a timeout expires), then presents a report through a
// valid/ready handshake. A confirmed deadlock parks the unit in DONE.
module denoise_top_hls_deadlock_report_unit
  import denoise_top_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM    = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W = idx_w(PROC_NUM)
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [IDX_W-1:0]    rpt_origin_idx,
  output logic [PROC_NUM-1:0] rpt_cycle_mask,
  output logic [HOPS_W-1:0]   rpt_hops,
  output logic                rpt_timeout,
  output logic                deadlock
);

  localparam logic [HOPS_W-1:0] TIMEOUT_V = HOPS_W'(TIMEOUT_CYC);

  state_t                state_reg;
  logic                  dl_detect_reg;
  logic [PROC_NUM-1:0]   origin_reg;
  logic                  rpt_valid_reg;
  logic [IDX_W-1:0]      origin_idx_reg;
  logic [PROC_NUM-1:0]   cycle_mask_reg;
  logic [HOPS_W-1:0]     hops_reg;
  logic                  rpt_timeout_reg;
  logic                  deadlock_reg;

  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_valid;
  logic [HOPS_W-1:0]     hops_next;
  logic                  origin_hit;
  logic                  timeout_hit;
  logic                  in_trace;

  function automatic logic [PROC_NUM-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  denoise_top_hls_deadlock_prio_enc #(
    .PROC_NUM (PROC_NUM)
  ) u_prio_enc (
    .req   (dl_in_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Hop count for the current TRACE cycle, saturating at all-ones
  assign hops_next   = (hops_reg == '1) ? hops_reg : hops_reg + 1'b1;
  assign in_trace    = (state_reg == TRACE);
  assign origin_hit  = dl_in_vec[origin_idx_reg];
  assign timeout_hit = (hops_next >= TIMEOUT_V);

  // Token is cleared when the origin re-reports, or once when the trace is
  // abandoned; gated by reset so nothing leaks out while it is held
  assign token_clear = reset & in_trace & (origin_hit | timeout_hit);

  assign dl_detect_out  = dl_detect_reg;
  assign origin         = origin_reg;
  assign rpt_valid      = rpt_valid_reg;
  assign rpt_origin_idx = origin_idx_reg;
  assign rpt_cycle_mask = cycle_mask_reg;
  assign rpt_hops       = hops_reg;
  assign rpt_timeout    = rpt_timeout_reg;
  assign deadlock       = deadlock_reg;

  // Controller FSM with registered outputs. The origin strobe is loaded while
  // in ORIGIN, so units see it on the first TRACE cycle (which counts as hop 1).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      dl_detect_reg   <= 1'b0;
      origin_reg      <= '0;
      rpt_valid_reg   <= 1'b0;
      origin_idx_reg  <= '0;
      cycle_mask_reg  <= '0;
      hops_reg        <= '0;
      rpt_timeout_reg <= 1'b0;
      deadlock_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enc_valid) begin
            origin_idx_reg <= enc_idx;
            cycle_mask_reg <= onehot(enc_idx);
            hops_reg       <= '0;
            dl_detect_reg  <= 1'b1;
            state_reg      <= ORIGIN;
          end
        end
        ORIGIN: begin
          origin_reg <= onehot(origin_idx_reg);
          state_reg  <= TRACE;
        end
        TRACE: begin
          origin_reg     <= '0;
          cycle_mask_reg <= cycle_mask_reg | dl_in_vec;
          hops_reg       <= hops_next;
          if (origin_hit) begin
            // A return beats a coincident timeout
            deadlock_reg    <= 1'b1;
            rpt_timeout_reg <= 1'b0;
            rpt_valid_reg   <= 1'b1;
            state_reg       <= REPORT;
          end else if (timeout_hit) begin
            rpt_timeout_reg <= 1'b1;
            rpt_valid_reg   <= 1'b1;
            state_reg       <= REPORT;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid_reg <= 1'b0;
            if (deadlock_reg) begin
              state_reg <= DONE;
            end else begin
              dl_detect_reg <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_denoise_top_hls_deadlock_report_unit.sv
// Scoreboard bench for the deadlock report unit (PROC_NUM=4, TIMEOUT_CYC=8).
// Stimulus pushes expected reports; a negedge monitor compares every cycle a
// report is presented and pops on acceptance.
module tb_denoise_top_hls_deadlock_report_unit;

  logic        reset;
  logic        clock;
  logic [3:0]  dl_in_vec;
  logic        dl_detect_out;
  logic [3:0]  origin;
  logic        token_clear;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [1:0]  rpt_origin_idx;
  logic [3:0]  rpt_cycle_mask;
  logic [15:0] rpt_hops;
  logic        rpt_timeout;
  logic        deadlock;

  typedef struct {
    logic [1:0]  idx;
    logic [3:0]  mask;
    logic [15:0] hops;
    logic        to;
    logic        dl;
  } rpt_t;

  rpt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  denoise_top_hls_deadlock_report_unit #(
    .PROC_NUM    (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .reset          (reset),
    .clock          (clock),
    .dl_in_vec      (dl_in_vec),
    .dl_detect_out  (dl_detect_out),
    .origin         (origin),
    .token_clear    (token_clear),
    .rpt_valid      (rpt_valid),
    .rpt_ready      (rpt_ready),
    .rpt_origin_idx (rpt_origin_idx),
    .rpt_cycle_mask (rpt_cycle_mask),
    .rpt_hops       (rpt_hops),
    .rpt_timeout    (rpt_timeout),
    .deadlock       (deadlock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic [3:0] mask,
                      input logic [15:0] hops, input logic to, input logic dl);
    rpt_t r;
    r.idx = idx; r.mask = mask; r.hops = hops; r.to = to; r.dl = dl;
    exp_q.push_back(r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dl_detect"}, 32'(dl_detect_out), 0);
    chk({tag, "_origin"}, 32'(origin), 0);
    chk({tag, "_token_clear"}, 32'(token_clear), 0);
    chk({tag, "_rpt_valid"}, 32'(rpt_valid), 0);
    chk({tag, "_rpt_idx"}, 32'(rpt_origin_idx), 0);
    chk({tag, "_rpt_mask"}, 32'(rpt_cycle_mask), 0);
    chk({tag, "_rpt_hops"}, 32'(rpt_hops), 0);
    chk({tag, "_rpt_timeout"}, 32'(rpt_timeout), 0);
    chk({tag, "_deadlock"}, 32'(deadlock), 0);
  endtask

  // Monitor: every presented report must match the head of the scoreboard
  always @(negedge clock) begin
    if (rpt_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rpt_unexpected", 32'(rpt_valid), 0);
      end else begin
        chk("rpt_idx", 32'(rpt_origin_idx), 32'(exp_q[0].idx));
        chk("rpt_mask", 32'(rpt_cycle_mask), 32'(exp_q[0].mask));
        chk("rpt_hops", 32'(rpt_hops), 32'(exp_q[0].hops));
        chk("rpt_timeout", 32'(rpt_timeout), 32'(exp_q[0].to));
        chk("rpt_deadlock", 32'(deadlock), 32'(exp_q[0].dl));
        if (rpt_ready === 1'b1) begin
          $display("report accepted: idx=%0d mask=%b hops=%0d timeout=%0b deadlock=%0b",
                   rpt_origin_idx, rpt_cycle_mask, rpt_hops, rpt_timeout, deadlock);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    dl_in_vec = '0;
    rpt_ready = 1'b0;
    #1;
    chk_zero("reset");
    tick(); tick();
    reset = 1'b1;
    tick();

    // Origin select, one-cycle origin strobe, traced return
    dl_in_vec = 4'b0100;
    tick();
    dl_in_vec = 4'b0000;
    chk("s1_detect", 32'(dl_detect_out), 1);
    chk("s1_origin_early", 32'(origin), 0);
    tick();
    chk("s1_origin", 32'(origin), 32'h4);
    dl_in_vec = 4'b0010;
    #1 chk("s2_tc_c1", 32'(token_clear), 0);
    tick();
    chk("s1_origin_once", 32'(origin), 0);
    dl_in_vec = 4'b1000;
    #1 chk("s2_tc_c2", 32'(token_clear), 0);
    tick();
    dl_in_vec = 4'b0100;
    #1 chk("s2_tc_return", 32'(token_clear), 1);
    push(2'd2, 4'b1110, 16'd3, 1'b0, 1'b1);
    tick();

    // Stall in REPORT with input activity; monitor checks stability
    dl_in_vec = 4'b1111;
    #1 chk("s5_tc_report", 32'(token_clear), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("s5_valid_held", 32'(rpt_valid), 1);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("s5_valid_done", 32'(rpt_valid), 0);
    chk("s5_detect_done", 32'(dl_detect_out), 1);
    chk("s5_deadlock_done", 32'(deadlock), 1);
    dl_in_vec = 4'b0001;
    tick(); tick();
    chk("s5_done_valid", 32'(rpt_valid), 0);
    chk("s5_done_idx", 32'(rpt_origin_idx), 2);
    chk("s5_done_mask", 32'(rpt_cycle_mask), 32'hE);
    chk("s5_done_tc", 32'(token_clear), 0);
    chk("s5_done_origin", 32'(origin), 0);
    dl_in_vec = 4'b0000;

    // Leave DONE through reset
    reset = 1'b0;
    #1 chk_zero("done_reset");
    tick();
    reset = 1'b1;
    tick();

    // Lowest set index wins, then trace abandoned on timeout
    dl_in_vec = 4'b1010;
    tick();
    dl_in_vec = 4'b0000;
    chk("s3_idx", 32'(rpt_origin_idx), 1);
    tick();
    chk("s3_origin", 32'(origin), 32'h2);
    for (int k = 1; k <= 8; k++) begin
      dl_in_vec = (k == 2) ? 4'b0100 : 4'b0000;
      #1 chk($sformatf("s4_tc_c%0d", k), 32'(token_clear), (k == 8) ? 1 : 0);
      if (k == 8) push(2'd1, 4'b0110, 16'd8, 1'b1, 1'b0);
      tick();
    end
    dl_in_vec = 4'b0000;
    #1 chk("s4_tc_after", 32'(token_clear), 0);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("s4_idle_detect", 32'(dl_detect_out), 0);
    chk("s4_idle_valid", 32'(rpt_valid), 0);
    chk("s4_idle_deadlock", 32'(deadlock), 0);
    tick();

    // Reset in the middle of a trace discards it
    dl_in_vec = 4'b0001;
    tick();
    dl_in_vec = 4'b0000;
    tick(); tick();
    dl_in_vec = 4'b0001;
    reset = 1'b0;
    #1 chk_zero("s6_reset");
    tick();
    chk_zero("s6_held");
    dl_in_vec = 4'b0000;
    reset = 1'b1;
    tick();

    // Return and timeout in the same cycle: return wins
    dl_in_vec = 4'b0001;
    tick();
    dl_in_vec = 4'b0000;
    tick();
    for (int k = 1; k <= 8; k++) begin
      dl_in_vec = (k == 8) ? 4'b0001 : 4'b0000;
      #1 chk($sformatf("tie_tc_c%0d", k), 32'(token_clear), (k == 8) ? 1 : 0);
      if (k == 8) push(2'd0, 4'b0001, 16'd8, 1'b0, 1'b1);
      tick();
    end
    dl_in_vec = 4'b0000;
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("tie_deadlock", 32'(deadlock), 1);
    chk("tie_timeout", 32'(rpt_timeout), 0);
    chk("tie_valid", 32'(rpt_valid), 0);
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
